// File: rtl/wb_pkg.sv
// Shared definitions for the register file, decode and write-back stages.
// Includes the load-use hazard helper used by the scoreboard.
package wb_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREGS  = 16;
    localparam int unsigned REG_AW = $clog2(NREGS);

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] data_t;

    // A same-cycle write-back to r resolves the hazard via the read bypass.
    function automatic logic hazard(input logic [NREGS-1:0] pend, input reg_addr_t r,
                                    input logic wb_we, input reg_addr_t wb_addr);
        return (r != '0) && pend[r] && !(wb_we && (wb_addr == r));
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Load-use scoreboard: per-register load-in-flight bits and decode stall.
// Set on issuing a load, cleared by the matching write-back; set wins a tie.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wb_we,
    input  reg_addr_t        i_wb_addr,
    input  reg_addr_t        i_rd_addr_a,
    input  reg_addr_t        i_rd_addr_b,
    input  logic             i_iss_valid,
    input  logic             i_iss_use_a,
    input  logic             i_iss_use_b,
    input  logic             i_iss_load,
    input  reg_addr_t        i_iss_dest,
    output logic             o_stall,
    output logic [NREGS-1:0] o_pending
);

    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_pending_nxt;
    logic             w_stall;
    logic             w_issue;

    always_comb begin
        w_stall = i_iss_valid &&
                  ((i_iss_use_a && hazard(r_pending, i_rd_addr_a, i_wb_we, i_wb_addr)) ||
                   (i_iss_use_b && hazard(r_pending, i_rd_addr_b, i_wb_we, i_wb_addr)) ||
                   (i_iss_load  && hazard(r_pending, i_iss_dest,  i_wb_we, i_wb_addr)));
        w_issue = i_iss_valid && !w_stall;
    end

    // Clear first, then set, so a simultaneous load issue to the same register wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (i_wb_we && (i_wb_addr != '0)) begin
            w_pending_nxt[i_wb_addr] = 1'b0;
        end
        if (w_issue && i_iss_load && (i_iss_dest != '0)) begin
            w_pending_nxt[i_iss_dest] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign o_stall   = w_stall;
    assign o_pending = r_pending;

endmodule

// File: rtl/wb_regfile.sv
// Write-back register file with two bypassed combinational read ports and a
// load-use scoreboard that stalls decode on outstanding loads.
module wb_regfile
    import wb_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wb_we,
    input  reg_addr_t        i_wb_addr,
    input  data_t            i_wb_data,
    input  reg_addr_t        i_rd_addr_a,
    input  reg_addr_t        i_rd_addr_b,
    output data_t            o_rd_data_a,
    output data_t            o_rd_data_b,
    input  logic             i_iss_valid,
    input  logic             i_iss_use_a,
    input  logic             i_iss_use_b,
    input  logic             i_iss_load,
    input  reg_addr_t        i_iss_dest,
    output logic             o_stall,
    output logic [NREGS-1:0] o_pending
);

    data_t r_regs [NREGS];

    // R0 is never written; its reads are forced to zero below.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wb_we && (i_wb_addr != '0)) begin
            r_regs[i_wb_addr] <= i_wb_data;
        end
    end

    always_comb begin
        if (i_rd_addr_a == '0) begin
            o_rd_data_a = '0;
        end else if (i_wb_we && (i_wb_addr == i_rd_addr_a)) begin
            o_rd_data_a = i_wb_data;
        end else begin
            o_rd_data_a = r_regs[i_rd_addr_a];
        end

        if (i_rd_addr_b == '0) begin
            o_rd_data_b = '0;
        end else if (i_wb_we && (i_wb_addr == i_rd_addr_b)) begin
            o_rd_data_b = i_wb_data;
        end else begin
            o_rd_data_b = r_regs[i_rd_addr_b];
        end
    end

    wb_scoreboard u_scoreboard (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wb_we     (i_wb_we),
        .i_wb_addr   (i_wb_addr),
        .i_rd_addr_a (i_rd_addr_a),
        .i_rd_addr_b (i_rd_addr_b),
        .i_iss_valid (i_iss_valid),
        .i_iss_use_a (i_iss_use_a),
        .i_iss_use_b (i_iss_use_b),
        .i_iss_load  (i_iss_load),
        .i_iss_dest  (i_iss_dest),
        .o_stall     (o_stall),
        .o_pending   (o_pending)
    );

endmodule
